// File: rtl/muldiv_e.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle, with a stall request that freezes the front end.
module muldiv_e #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic [XLEN-1:0] result,
  output logic            done,
  output logic            busy,
  output logic            stall_req
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam int unsigned PW = 2 * XLEN;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              sign_a_q, sign_a_d;
  logic              sign_b_q, sign_b_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic              is_div, a_sop, b_sop, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0]   a_mag, b_mag, special;
  logic [XLEN:0]     mul_sum, div_hi;
  logic [XLEN+1:0]   div_trial;
  logic [PW-1:0]     mul_nx, div_nx, calc_nx, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fin;

  // Operand decode, one iteration step, and final sign correction
  always_comb begin
    is_div   = funct3[2];
    a_sop    = (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    b_sop    = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg    = a_sop && rs1_data[XLEN-1];
    b_neg    = b_sop && rs2_data[XLEN-1];
    a_mag    = a_neg ? (~rs1_data) + XLEN'(1) : rs1_data;
    b_mag    = b_neg ? (~rs2_data) + XLEN'(1) : rs2_data;
    div_zero = is_div && (rs2_data == '0);
    div_ovf  = is_div && !funct3[0] && (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) &&
               (rs2_data == '1);
    // Divide by zero: quotient all ones, remainder is A. Overflow: quotient is MIN, remainder 0.
    if (funct3[1]) special = div_zero ? rs1_data : '0;
    else           special = div_zero ? '1 : {1'b1, {(XLEN-1){1'b0}}};

    // Multiply: add multiplicand into the high half when the low bit is set, then shift right.
    mul_sum = {1'b0, acc_q[PW-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_nx  = {mul_sum, acc_q[XLEN-1:1]};

    // Divide: shift {rem,quo} left, keep the trial subtraction if it does not borrow.
    div_hi    = acc_q[PW-1:XLEN-1];
    div_trial = {1'b0, div_hi} - {2'b00, opnd_q};
    if (div_trial[XLEN+1]) div_nx = {div_hi[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    else                   div_nx = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    calc_nx  = op_q[2] ? div_nx : mul_nx;
    prod_fix = (sign_a_q ^ sign_b_q) ? (~calc_nx) + PW'(1) : calc_nx;
    quo_fix  = (sign_a_q ^ sign_b_q) ? (~calc_nx[XLEN-1:0]) + XLEN'(1) : calc_nx[XLEN-1:0];
    rem_fix  = sign_a_q ? (~calc_nx[PW-1:XLEN]) + XLEN'(1) : calc_nx[PW-1:XLEN];
    if (op_q[2])               fin = op_q[1] ? rem_fix : quo_fix;
    else if (op_q[1:0] == 2'b00) fin = prod_fix[XLEN-1:0];
    else                       fin = prod_fix[PW-1:XLEN];
  end

  // Next-state and register updates; flush overrides everything
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          op_d     = funct3;
          sign_a_d = a_neg;
          sign_b_d = b_neg;
          cnt_d    = '0;
          if (div_zero || div_ovf) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            result_d = special;
          end else begin
            state_d = S_CALC;
            acc_d   = is_div ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
            opnd_d  = is_div ? b_mag : a_mag;
          end
        end
      end
      S_CALC: begin
        acc_d = calc_nx;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(XLEN - 1)) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          result_d = fin;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d  = S_IDLE;
      done_d   = 1'b0;
      result_d = result_q;
    end
    busy_d = (state_d == S_CALC);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign result    = result_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign stall_req = (((state_q == S_IDLE) && start) || (state_q == S_CALC)) && !flush;

endmodule

// File: tb/tb_muldiv_e.sv
// Self-checking bench for muldiv_e: directed table, corner sequences, random vs model.
module tb_muldiv_e;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data;
  logic        flush;
  logic [31:0] result;
  logic        done, busy, stall_req;

  int checks = 0;
  int failures = 0;
  logic [31:0] last_exp = '0;

  muldiv_e #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
    .result(result), .done(done), .busy(busy), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // RV32M semantics computed with plain 64-bit arithmetic
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa, sb, sq;
    logic [63:0] ua, ub, p;
    sa = 64'($signed(a));
    sb = 64'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * $signed(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFFFFFF; sq = sa / sb; return sq[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFFFFFF; p = ua / ub; return p[31:0]; end
      3'd6: begin if (b == 0) return a; sq = sa % sb; return sq[31:0]; end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if (f[2] && !f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return 33;
  endfunction

  // Issue one op (start for one cycle); returns result, done cycle and stall-profile errors
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int elat, output logic [31:0] res, output int lat,
                        output int stall_bad);
    res = '0;
    lat = -1;
    stall_bad = 0;
    @(negedge clk);
    start = 1'b1; funct3 = f; rs1_data = a; rs2_data = b;
    #1;
    if (stall_req !== 1'b1) stall_bad++;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (stall_req !== (k < elat)) stall_bad++;
      if (done === 1'b1) begin
        res = result;
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    vec_t vt[12];
    logic [31:0] res;
    int lat, sbad, dcount, dcycle;
    logic [2:0] f;
    logic [31:0] a, b, e;

    vt[0]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33};
    vt[1]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    vt[2]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33};
    vt[3]  = '{3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33};
    vt[4]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
    vt[5]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
    vt[6]  = '{3'd5, 32'd100,      32'd7,        32'd14,       33};
    vt[7]  = '{3'd7, 32'd100,      32'd7,        32'd2,        33};
    vt[8]  = '{3'd5, 32'h1234,     32'd0,        32'hFFFFFFFF, 1};
    vt[9]  = '{3'd7, 32'h1234,     32'd0,        32'h1234,     1};
    vt[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vt[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};

    rst = 1'b1; start = 1'b0; funct3 = '0; rs1_data = '0; rs2_data = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_result", result, 32'h0);
    check("reset_done", {31'b0, done}, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_stall", {31'b0, stall_req}, 32'h0);

    // Directed table
    for (int i = 0; i < 12; i++) begin
      run_op(vt[i].f, vt[i].a, vt[i].b, vt[i].lat, res, lat, sbad);
      check($sformatf("vec%0d_result", i), res, vt[i].exp);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vt[i].lat));
      check($sformatf("vec%0d_stall", i), 32'(sbad), 32'h0);
      last_exp = vt[i].exp;
      if (i == 0) begin
        @(negedge clk);
        check("mul_busy_after", {31'b0, busy}, 32'h0);
        check("mul_done_one_cycle", {31'b0, done}, 32'h0);
      end
    end

    // Flush in cycle 10 of a DIV
    @(negedge clk);
    start = 1'b1; funct3 = 3'd4; rs1_data = 32'd100; rs2_data = 32'd7;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    flush = 1'b1;
    #1;
    check("flush_stall", {31'b0, stall_req}, 32'h0);
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {31'b0, busy}, 32'h0);
    dcount = 0;
    for (int k = 0; k < 40; k++) begin
      if (done === 1'b1) dcount++;
      @(negedge clk);
    end
    check("flush_no_done", 32'(dcount), 32'h0);
    check("flush_result_kept", result, last_exp);
    run_op(3'd0, 32'd3, 32'd5, 33, res, lat, sbad);
    check("after_flush_result", res, 32'd15);
    check("after_flush_latency", 32'(lat), 32'd33);
    last_exp = 32'd15;

    // Reset in cycle 20 of a MUL
    @(negedge clk);
    start = 1'b1; funct3 = 3'd0; rs1_data = 32'd9; rs2_data = 32'd11;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_result", result, 32'h0);
    check("midrst_done", {31'b0, done}, 32'h0);
    check("midrst_busy", {31'b0, busy}, 32'h0);
    dcount = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
    end
    check("midrst_no_done", 32'(dcount), 32'h0);

    // Start held through CALC and DONE: one pulse, no restart
    @(negedge clk);
    start = 1'b1; funct3 = 3'd0; rs1_data = 32'd6; rs2_data = 32'd7;
    dcount = 0; dcycle = -1;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (k == 34) start = 1'b0;
      if (done === 1'b1) begin
        dcount++;
        if (dcycle < 0) dcycle = k;
      end
    end
    check("held_done_count", 32'(dcount), 32'd1);
    check("held_done_cycle", 32'(dcycle), 32'd33);
    check("held_result", result, 32'd42);

    // Randomized ops against the model
    for (int i = 0; i < 200; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(0, 20)); end
        3: begin a = 32'h80000000 | 32'($urandom_range(0, 3)); end
        default: ;
      endcase
      e = model(f, a, b);
      run_op(f, a, b, exp_lat(f, a, b), res, lat, sbad);
      check($sformatf("rnd%0d_f%0d_a%08h_b%08h", i, f, a, b), res, e);
      check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(exp_lat(f, a, b)));
      check($sformatf("rnd%0d_stall", i), 32'(sbad), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
